// File: rtl/lsu_if.sv
`default_nettype none
// ============================================================================
//  Module      : lsu_if
//  Description : Core request/response and memory-side bundle for the LSU.
//  Revision    : 1.0 - initial release
// ============================================================================
interface lsu_if #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 32
);
   logic                  req_valid;
   logic                  req_ready;
   logic                  req_wen;
   logic [1:0]            req_size;
   logic                  req_unsigned;
   logic [ADDR_WIDTH-1:0] req_addr;
   logic [DATA_WIDTH-1:0] req_wdata;

   logic                  resp_valid;
   logic                  resp_ready;
   logic [DATA_WIDTH-1:0] resp_rdata;
   logic                  resp_err;

   logic                  mem_we;
   logic [1:0]            mem_format;
   logic [ADDR_WIDTH-1:0] mem_addr;
   logic [DATA_WIDTH-1:0] mem_wdata;
   logic [DATA_WIDTH-1:0] mem_rdata;

   // LSU view: accepts core requests, drives the memory port
   modport slave (
      input  req_valid, req_wen, req_size, req_unsigned, req_addr, req_wdata,
      output req_ready,
      output resp_valid, resp_rdata, resp_err,
      input  resp_ready,
      output mem_we, mem_format, mem_addr, mem_wdata,
      input  mem_rdata
   );

   // Environment view: core plus memory model
   modport master (
      output req_valid, req_wen, req_size, req_unsigned, req_addr, req_wdata,
      input  req_ready,
      input  resp_valid, resp_rdata, resp_err,
      output resp_ready,
      input  mem_we, mem_format, mem_addr, mem_wdata,
      output mem_rdata
   );
endinterface
`default_nettype wire

// File: rtl/lsu.sv
`default_nettype none
// ============================================================================
//  Module      : lsu
//  Description : Single-outstanding load/store unit with alignment check,
//                fixed-latency memory access and load sign/zero extension.
//  Revision    : 1.0 - initial release
// ============================================================================
module lsu #(
   parameter int DATA_WIDTH  = 32,
   parameter int ADDR_WIDTH  = 32,
   parameter int MEM_LATENCY = 1
) (
   input  wire  clk,
   input  wire  rst_n,
   lsu_if.slave bus
);
   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_ACCESS = 2'd1,
      S_RESP   = 2'd2
   } state_t;

   localparam logic [3:0] c_cnt_init = 4'(MEM_LATENCY - 1);

   state_t                r_state;
   state_t                w_state_nxt;
   logic [3:0]            r_cnt;
   logic [3:0]            w_cnt_nxt;
   logic                  r_wen;
   logic                  r_uns;
   logic [1:0]            r_size;
   logic [1:0]            r_format;
   logic [ADDR_WIDTH-1:0] r_addr;
   logic [DATA_WIDTH-1:0] r_wdata;
   logic [DATA_WIDTH-1:0] r_rdata;
   logic                  r_err;

   logic                  w_accept;
   logic                  w_final;
   logic                  w_misalign;
   logic [DATA_WIDTH-1:0] w_load_ext;

   assign w_accept   = (r_state == S_IDLE) && bus.req_valid;
   assign w_final    = (r_state == S_ACCESS) && (r_cnt == 4'd0);
   assign w_misalign = ((bus.req_size == 2'b01) && bus.req_addr[0]) ||
                       (bus.req_size[1] && (bus.req_addr[1:0] != 2'b00));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_cnt   <= 4'd0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      case (r_state)
         S_IDLE: begin
            if (bus.req_valid) begin
               if (w_misalign) begin
                  w_state_nxt = S_RESP;
               end else begin
                  w_state_nxt = S_ACCESS;
                  w_cnt_nxt   = c_cnt_init;
               end
            end
         end
         S_ACCESS: begin
            // The counter parks at zero on the way out of ACCESS
            if (r_cnt == 4'd0) begin
               w_state_nxt = S_RESP;
            end else begin
               w_cnt_nxt = r_cnt - 4'd1;
            end
         end
         S_RESP: begin
            if (bus.resp_ready) begin
               w_state_nxt = S_IDLE;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Masking by size is implicit: only the low byte/half feeds the result
   always_comb begin
      w_load_ext = bus.mem_rdata;
      case (r_size)
         2'b00:   w_load_ext = {{(DATA_WIDTH-8){~r_uns & bus.mem_rdata[7]}},
                                bus.mem_rdata[7:0]};
         2'b01:   w_load_ext = {{(DATA_WIDTH-16){~r_uns & bus.mem_rdata[15]}},
                                bus.mem_rdata[15:0]};
         default: w_load_ext = bus.mem_rdata;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wen    <= 1'b0;
         r_uns    <= 1'b0;
         r_size   <= 2'b00;
         r_format <= 2'b00;
         r_addr   <= '0;
         r_wdata  <= '0;
         r_rdata  <= '0;
         r_err    <= 1'b0;
      end else begin
         if (w_accept) begin
            r_wen  <= bus.req_wen;
            r_uns  <= bus.req_unsigned;
            r_size <= bus.req_size;
            if (w_misalign) begin
               r_rdata <= '0;
               r_err   <= 1'b1;
            end else begin
               // Memory-side registers only move for requests that reach ACCESS
               r_addr   <= bus.req_addr;
               r_wdata  <= bus.req_wdata;
               r_format <= (bus.req_size == 2'b11) ? 2'b10 : bus.req_size;
            end
         end
         if (w_final) begin
            r_rdata <= r_wen ? '0 : w_load_ext;
            r_err   <= 1'b0;
         end
      end
   end

   assign bus.req_ready  = (r_state == S_IDLE);
   assign bus.resp_valid = (r_state == S_RESP);
   assign bus.resp_rdata = r_rdata;
   assign bus.resp_err   = r_err;
   assign bus.mem_we     = w_final && r_wen;
   assign bus.mem_format = r_format;
   assign bus.mem_addr   = r_addr;
   assign bus.mem_wdata  = r_wdata;

endmodule
`default_nettype wire

// File: tb/tb_lsu.sv
`default_nettype none
// ============================================================================
//  Module      : tb_lsu
//  Description : Self-checking bench; three LSUs (latency 1, 3, 4) share one
//                stimulus stream and are each compared against a reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_lsu;
   logic        clk = 1'b0;
   logic        rst_n;
   logic        req_valid, req_wen, req_unsigned, resp_ready;
   logic [1:0]  req_size;
   logic [31:0] req_addr, req_wdata, mem_rdata;

   logic [2:0]       req_ready_a, resp_valid_a, resp_err_a, mem_we_a;
   logic [2:0][31:0] rdata_a, mem_addr_a, mem_wdata_a;
   logic [2:0][1:0]  mem_fmt_a;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] load_value(input logic [31:0] d, input logic [1:0] size,
                                              input bit uns);
      longint v;
      if (size == 2'd0) begin
         v = d % 256;
         if (!uns && v >= 128) v -= 256;
      end else if (size == 2'd1) begin
         v = d % 65536;
         if (!uns && v >= 32768) v -= 65536;
      end else begin
         v = d;
      end
      return v[31:0];
   endfunction

   function automatic bit misaligned(input logic [1:0] size, input logic [31:0] addr);
      return ((size == 2'd1) && (addr % 2 != 0)) || ((size >= 2'd2) && (addr % 4 != 0));
   endfunction

   for (genvar g = 0; g < 3; g++) begin : g_dut
      localparam int LAT = (g == 0) ? 1 : (g == 1) ? 3 : 4;

      lsu_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) bus ();

      lsu #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .MEM_LATENCY(LAT)) u_dut (
         .clk   (clk),
         .rst_n (rst_n),
         .bus   (bus.slave)
      );

      assign bus.req_valid    = req_valid;
      assign bus.req_wen      = req_wen;
      assign bus.req_size     = req_size;
      assign bus.req_unsigned = req_unsigned;
      assign bus.req_addr     = req_addr;
      assign bus.req_wdata    = req_wdata;
      assign bus.resp_ready   = resp_ready;
      assign bus.mem_rdata    = mem_rdata;

      assign req_ready_a[g]  = bus.req_ready;
      assign resp_valid_a[g] = bus.resp_valid;
      assign resp_err_a[g]   = bus.resp_err;
      assign mem_we_a[g]     = bus.mem_we;
      assign rdata_a[g]      = bus.resp_rdata;
      assign mem_addr_a[g]   = bus.mem_addr;
      assign mem_wdata_a[g]  = bus.mem_wdata;
      assign mem_fmt_a[g]    = bus.mem_format;

      // Reference: m_acc = memory cycles still owed, m_resp = response pending
      int          m_acc;
      bit          m_resp, m_err, m_wen, m_uns;
      logic [1:0]  m_size, m_fmt;
      logic [31:0] m_rdata, m_addr, m_wdata;

      always @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            m_acc <= 0;  m_resp <= 0;  m_err <= 0;  m_wen <= 0;  m_uns <= 0;
            m_size <= 0; m_fmt <= 0;   m_rdata <= 0; m_addr <= 0; m_wdata <= 0;
         end else if (m_resp) begin
            if (resp_ready) m_resp <= 0;
         end else if (m_acc > 0) begin
            m_acc <= m_acc - 1;
            if (m_acc == 1) begin
               m_resp  <= 1;
               m_err   <= 0;
               m_rdata <= m_wen ? 32'h0 : load_value(mem_rdata, m_size, m_uns);
            end
         end else if (req_valid) begin
            m_wen  <= req_wen;
            m_size <= req_size;
            m_uns  <= req_unsigned;
            if (misaligned(req_size, req_addr)) begin
               m_resp  <= 1;
               m_err   <= 1;
               m_rdata <= 0;
            end else begin
               m_acc   <= LAT;
               m_addr  <= req_addr;
               m_wdata <= req_wdata;
               m_fmt   <= (req_size == 2'd3) ? 2'd2 : req_size;
            end
         end
      end

      always @(negedge clk) begin
         check_eq($sformatf("L%0d req_ready", LAT), 32'(bus.req_ready), 32'(!m_resp && m_acc == 0));
         check_eq($sformatf("L%0d resp_valid", LAT), 32'(bus.resp_valid), 32'(m_resp));
         check_eq($sformatf("L%0d mem_we", LAT), 32'(bus.mem_we), 32'(m_acc == 1 && m_wen));
         check_eq($sformatf("L%0d mem_addr", LAT), bus.mem_addr, m_addr);
         check_eq($sformatf("L%0d mem_wdata", LAT), bus.mem_wdata, m_wdata);
         check_eq($sformatf("L%0d mem_format", LAT), 32'(bus.mem_format), 32'(m_fmt));
         if (m_resp || !rst_n) begin
            check_eq($sformatf("L%0d resp_rdata", LAT), bus.resp_rdata, m_rdata);
            check_eq($sformatf("L%0d resp_err", LAT), 32'(bus.resp_err), 32'(m_err));
         end
      end
   end

   // Issue one request starting at a falling edge; returns one cycle later
   task automatic send(input bit wen, input logic [1:0] size, input bit uns,
                       input logic [31:0] addr, input logic [31:0] wdata);
      req_wen      = wen;
      req_size     = size;
      req_unsigned = uns;
      req_addr     = addr;
      req_wdata    = wdata;
      req_valid    = 1'b1;
      @(negedge clk);
      req_valid = 1'b0;
   endtask

   task automatic wait_idle(input string tag);
      int n = 0;
      while (req_ready_a != 3'b111 && n < 40) begin
         @(negedge clk);
         n++;
      end
      check_eq({tag, " idle"}, 32'(req_ready_a), 32'h7);
   endtask

   initial begin
      int n;
      rst_n = 1'b0;  req_valid = 1'b0; req_wen = 1'b0; req_unsigned = 1'b0;
      req_size = 2'd0; req_addr = 32'h0; req_wdata = 32'h0; mem_rdata = 32'h0;
      resp_ready = 1'b1;
      repeat (3) @(negedge clk);
      check_eq("reset req_ready", 32'(req_ready_a), 32'h7);
      check_eq("reset resp_valid", 32'(resp_valid_a), 32'h0);
      check_eq("reset mem_addr", mem_addr_a[2], 32'h0);

      // Signed byte load, first request straight out of reset
      rst_n     = 1'b1;
      mem_rdata = 32'h000000F3;
      send(1'b0, 2'b00, 1'b0, 32'h80000001, 32'h0);
      check_eq("first accept", 32'(req_ready_a), 32'h0);
      check_eq("sb L1 valid early", 32'(resp_valid_a[0]), 32'h0);
      @(negedge clk);
      check_eq("sb L1 valid", 32'(resp_valid_a[0]), 32'h1);
      check_eq("sb L1 rdata", rdata_a[0], 32'hFFFFFFF3);
      check_eq("sb L1 err", 32'(resp_err_a[0]), 32'h0);
      wait_idle("sb");

      // Unsigned half load
      mem_rdata = 32'h12348001;
      send(1'b0, 2'b01, 1'b1, 32'h80000002, 32'h0);
      @(negedge clk);
      check_eq("uh L1 rdata", rdata_a[0], 32'h00008001);
      wait_idle("uh");
      check_eq("uh L4 rdata", rdata_a[2], 32'h00008001);

      // Word store, latency 3: strobe only in the third ACCESS cycle
      send(1'b1, 2'b10, 1'b0, 32'h80000004, 32'hDEADBEEF);
      check_eq("ws L3 we c1", 32'(mem_we_a[1]), 32'h0);
      @(negedge clk);
      check_eq("ws L3 we c2", 32'(mem_we_a[1]), 32'h0);
      @(negedge clk);
      check_eq("ws L3 we c3", 32'(mem_we_a[1]), 32'h1);
      check_eq("ws L3 format", 32'(mem_fmt_a[1]), 32'h2);
      check_eq("ws L3 addr", mem_addr_a[1], 32'h80000004);
      check_eq("ws L3 wdata", mem_wdata_a[1], 32'hDEADBEEF);
      @(negedge clk);
      check_eq("ws L3 we after", 32'(mem_we_a[1]), 32'h0);
      check_eq("ws L3 valid", 32'(resp_valid_a[1]), 32'h1);
      check_eq("ws L3 rdata", rdata_a[1], 32'h0);
      check_eq("ws L3 err", 32'(resp_err_a[1]), 32'h0);
      wait_idle("ws");

      // Misaligned half store: immediate error response, memory untouched
      send(1'b1, 2'b01, 1'b0, 32'h80000003, 32'h11112222);
      check_eq("mis valid", 32'(resp_valid_a), 32'h7);
      check_eq("mis err", 32'(resp_err_a), 32'h7);
      check_eq("mis rdata", rdata_a[2], 32'h0);
      check_eq("mis we", 32'(mem_we_a), 32'h0);
      check_eq("mis addr held", mem_addr_a[0], 32'h80000004);
      wait_idle("mis");

      // Backpressure on the response, with a request presented meanwhile
      resp_ready = 1'b0;
      mem_rdata  = 32'hA5A51234;
      send(1'b0, 2'b11, 1'b0, 32'h80000008, 32'h0);
      n = 0;
      while (resp_valid_a != 3'b111 && n < 20) begin
         @(negedge clk);
         n++;
      end
      check_eq("bp all valid", 32'(resp_valid_a), 32'h7);
      req_valid = 1'b1;
      req_addr  = 32'h80000010;
      for (int i = 0; i < 5; i++) begin
         check_eq("bp valid", 32'(resp_valid_a), 32'h7);
         check_eq("bp rdata L3", rdata_a[1], 32'hA5A51234);
         check_eq("bp ready", 32'(req_ready_a), 32'h0);
         check_eq("bp format L4", 32'(mem_fmt_a[2]), 32'h2);
         @(negedge clk);
      end
      req_valid  = 1'b0;
      resp_ready = 1'b1;
      @(negedge clk);
      check_eq("bp ready after", 32'(req_ready_a), 32'h7);
      check_eq("bp valid after", 32'(resp_valid_a), 32'h0);

      // Reset pulse in ACCESS cycle 2 of a latency-4 store
      send(1'b1, 2'b10, 1'b0, 32'h80000020, 32'hCAFEF00D);
      @(negedge clk);
      #1 rst_n = 1'b0;
      #1;
      check_eq("rst ready", 32'(req_ready_a), 32'h7);
      check_eq("rst valid", 32'(resp_valid_a), 32'h0);
      check_eq("rst err", 32'(resp_err_a), 32'h0);
      check_eq("rst we", 32'(mem_we_a), 32'h0);
      check_eq("rst rdata", rdata_a[2], 32'h0);
      check_eq("rst addr", mem_addr_a[2], 32'h0);
      check_eq("rst wdata", mem_wdata_a[2], 32'h0);
      check_eq("rst format", 32'(mem_fmt_a[2]), 32'h0);
      #1 rst_n = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         check_eq("rst no we", 32'(mem_we_a[2]), 32'h0);
         check_eq("rst no valid", 32'(resp_valid_a[2]), 32'h0);
      end
      mem_rdata = 32'hFFFFFF80;
      send(1'b0, 2'b00, 1'b1, 32'h80000011, 32'h0);
      wait_idle("post rst");
      check_eq("post rst L4 rdata", rdata_a[2], 32'h00000080);

      // Random traffic against the reference models
      for (int c = 0; c < 600; c++) begin
         req_valid    = ($urandom_range(0, 1) == 1);
         req_wen      = ($urandom_range(0, 1) == 1);
         req_size     = 2'($urandom_range(0, 3));
         req_unsigned = ($urandom_range(0, 1) == 1);
         req_addr     = $urandom;
         if ($urandom_range(0, 1) == 1) req_addr[1:0] = 2'b00;
         req_wdata    = $urandom;
         mem_rdata    = $urandom;
         resp_ready   = ($urandom_range(0, 3) != 0);
         @(negedge clk);
      end
      req_valid  = 1'b0;
      resp_ready = 1'b1;
      wait_idle("rand");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, time %0t", $time);
      $fatal(1);
   end

endmodule
`default_nettype wire

// File: doc/lsu.md
LSU -- requirements
Module: lsu

Interface
REQ-001 The module SHALL have parameter DATA_WIDTH, default 32, meaning data bus width.
REQ-002 The module SHALL have parameter ADDR_WIDTH, default 32, meaning address bus width.
REQ-003 The module SHALL have parameter MEM_LATENCY, default 1, legal range 1..15, meaning ACCESS cycles per transfer.
REQ-004 The module SHALL have port clk, input, 1 bit; it is the single clock, and all state changes on its rising edge.
REQ-005 The module SHALL have port rst_n, input, 1 bit; it is an asynchronous, active-low reset.
REQ-006 The module SHALL have the following core-side request ports:
- req_valid, input, 1 bit: request present.
- req_ready, output, 1 bit: LSU can accept a request.
- req_wen, input, 1 bit: 1 = store, 0 = load.
- req_size, input, 2 bits: 00 = byte, 01 = half, 10 = word, 11 = treated as word.
- req_unsigned, input, 1 bit: zero-extend loads.
- req_addr, input, ADDR_WIDTH bits: byte address.
- req_wdata, input, DATA_WIDTH bits: store data, right-aligned.
REQ-007 The module SHALL have the following core-side response ports:
- resp_valid, output, 1 bit: response present.
- resp_ready, input, 1 bit: core accepts the response.
- resp_rdata, output, DATA_WIDTH bits: extended load data, 0 for stores.
- resp_err, output, 1 bit: misaligned request.
REQ-008 The module SHALL have the following memory-side ports:
- mem_we, output, 1 bit: write strobe.
- mem_format, output, 2 bits: size to memory.
- mem_addr, output, ADDR_WIDTH bits: write and read address.
- mem_wdata, output, DATA_WIDTH bits: store data.
- mem_rdata, input, DATA_WIDTH bits: combinational read data, upper bytes possibly masked.

Function
REQ-009 The module SHALL implement states IDLE, ACCESS and RESP, encoded in one state register.
REQ-010 req_ready SHALL equal 1 exactly when the state is IDLE, and SHALL be driven from the register only, with no combinational path from any input.
REQ-011 A handshake is req_valid & req_ready at a rising edge; on it the LSU SHALL latch wen, size, unsigned, addr and wdata.
REQ-012 A request SHALL be misaligned when size=01 with addr[0]=1, or size=1x with addr[1:0]!=00.
REQ-013 On an aligned handshake the state SHALL go IDLE->ACCESS and load a latency counter with MEM_LATENCY-1.
REQ-014 On a misaligned handshake the state SHALL go IDLE->RESP with resp_err=1 and resp_rdata=0, and mem_we SHALL never assert for that request.
REQ-015 In ACCESS, mem_addr, mem_format and mem_wdata SHALL hold the latched values, and the counter SHALL decrement each cycle.
REQ-016 The final ACCESS cycle is the one where the counter equals 0; ACCESS->RESP SHALL occur at the end of that cycle.
REQ-017 mem_we SHALL be 1 only in the final ACCESS cycle of a store, and therefore SHALL be high for exactly one cycle per store.
REQ-018 For a load, mem_rdata SHALL be sampled at the end of the final ACCESS cycle.
REQ-019 Before extension, a sampled load value SHALL be masked by size: byte keeps [7:0], half keeps [15:0], word keeps all bits.
REQ-020 Load extension SHALL be:
- byte: sign bit 7, or zero-extend if unsigned.
- half: sign bit 15, or zero-extend if unsigned.
- word: unchanged.
REQ-021 A store response SHALL have resp_rdata=0 and resp_err=0.
REQ-022 In RESP, resp_valid SHALL be 1, and resp_rdata and resp_err SHALL be stable until the handshake.
REQ-023 The response handshake is resp_valid & resp_ready at a rising edge; it SHALL cause RESP->IDLE.
REQ-024 The next request SHALL NOT be accepted in the same cycle as the response handshake; minimum request-to-request spacing is MEM_LATENCY+2 cycles.
REQ-025 Outside ACCESS, mem_we SHALL be 0 and mem_addr, mem_format and mem_wdata SHALL hold their last values.
REQ-026 Request inputs SHALL be ignored outside IDLE, and resp_ready SHALL be ignored outside RESP.
REQ-027 For counter wrap-around, a counter equal to 0 in ACCESS SHALL never decrement below 0.

Reset
REQ-028 While rst_n=0, asynchronously, the LSU SHALL force the following:
- state = IDLE and counter = 0.
- req_ready=1, resp_valid=0, resp_err=0, resp_rdata=0.
- mem_we=0, mem_format=00, mem_addr=0, mem_wdata=0.
REQ-029 Reset asserted during ACCESS SHALL abort the request with mem_we=0, so no store occurs if reset precedes its final cycle, and no response is ever issued for the aborted request.
REQ-030 After rst_n deasserts, the first request SHALL be accepted on the first rising edge with req_valid=1.

Verification
REQ-031 The bench SHALL cover a signed byte load with MEM_LATENCY=1: addr 0x80000001, mem_rdata 0x000000F3, unsigned=0 -> resp_rdata 0xFFFFFFF3, err 0, resp_valid 2 cycles after the request handshake.
REQ-032 The bench SHALL cover an unsigned half load: addr 0x80000002, mem_rdata 0x1234_8001, unsigned=1 -> resp_rdata 0x00008001.
REQ-033 The bench SHALL cover a word store with MEM_LATENCY=3: addr 0x80000004, wdata 0xDEADBEEF -> mem_we high for exactly 1 cycle (the 3rd ACCESS cycle) with format 10 -> resp_rdata 0, err 0.
REQ-034 The bench SHALL cover a misaligned half store: addr 0x80000003 -> resp_err 1, mem_we never 1, resp_valid on the cycle after the handshake.
REQ-035 The bench SHALL cover backpressure: resp_ready held 0 for 5 cycles -> resp_valid and resp_rdata stable throughout, req_ready 0, and req_ready 1 on the cycle after the response handshake.
REQ-036 The bench SHALL cover reset during a store with MEM_LATENCY=4: rst_n pulsed low in ACCESS cycle 2 -> no mem_we pulse, no resp_valid, all outputs at reset values, and the next load completes normally.
